dsp_wave_capture: RTL

//  Triggered oscilloscope-style capture stage feeding the waveform visualisers.
//  - Takes the raw ADC sample stream, strobed by AUD_ADCLRCK edges, and decimates it by block averaging.
//  - Arms on a rising zero crossing and records DEPTH points into a ping-pong buffer.
//  - Swaps banks at VSync, so the display reads a stable, phase-locked frame.
//  - Sits between adcRead/int_ovReduce and the visual_* modules. Pixel X drives the read port.

---
 rtl/dsp_wave_capture.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_wave_capture.sv
// dsp_wave_capture: oscilloscope-style capture stage. Decimates the ADC stream
// by block averaging, arms on a rising zero crossing (or a timeout), records
// DEPTH points into one half of a ping-pong RAM and hands the finished frame
// to the display side at the next vsync.
//
// Strobe protocol: smp_stb, vs_stb and pt_stb are single-cycle pulses. There is
// no back-pressure anywhere; a consumer must act in the cycle the pulse is high.
// The one exception is vs_stb outside DONE, which is deliberately dropped so
// the display keeps the previous complete frame.
module dsp_wave_capture #(
    parameter int WS           = 16,
    parameter int DEPTH        = 640,
    parameter int AW           = 10,
    parameter int DECIM_LOG2   = 2,
    parameter int TRIG_TIMEOUT = 4096
) (
    input  logic          iCLK_50,
    input  logic          iRST_N,
    input  logic          iLRCK,
    input  logic [WS-1:0] iSAMPLE,
    input  logic          iVS,
    input  logic          iTRIG_EN,
    input  logic [AW-1:0] iRD_ADDR,
    output logic [WS-1:0] oRD_DATA,
    output logic          oBANK,
    output logic          oTRIGGERED,
    output logic          oFRAME_RDY,
    output logic [1:0]    oDBG_STATE
);

    localparam int ACCW = WS + DECIM_LOG2;
    localparam int TW   = $clog2(TRIG_TIMEOUT) + 1;

    localparam logic [DECIM_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [AW-1:0]         ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]           DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0]         TCNT_LAST = TW'(TRIG_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers for the two asynchronous inputs
    // ------------------------------------------------------------------
    logic lrck_s1_q, lrck_s2_q, lrck_e_q;
    logic vs_s1_q, vs_s2_q, vs_e_q;
    logic smp_stb, vs_stb;

    // Two-flop synchronisers plus an edge register for LRCK and VS.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            lrck_e_q  <= 1'b0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_e_q    <= 1'b0;
        end else begin
            lrck_s1_q <= iLRCK;
            lrck_s2_q <= lrck_s1_q;
            lrck_e_q  <= lrck_s2_q;
            vs_s1_q   <= iVS;
            vs_s2_q   <= vs_s1_q;
            vs_e_q    <= vs_s2_q;
        end
    end

    assign smp_stb = lrck_s2_q & ~lrck_e_q;
    assign vs_stb  = vs_s2_q & ~vs_e_q;

    // ------------------------------------------------------------------
    // Block-average decimator
    // ------------------------------------------------------------------
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] sample_ext, acc_sum, acc_shr;
    logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
    logic [WS-1:0]          pt_q, pt_d;
    logic [WS-1:0]          prev_pt_q, prev_pt_d;
    logic                   pt_stb_q, pt_stb_d;

    // Accumulate each strobed sample; the last one of a block emits the floor mean.
    always_comb begin
        sample_ext = {{DECIM_LOG2{iSAMPLE[WS-1]}}, iSAMPLE};
        acc_sum    = acc_q + sample_ext;
        acc_shr    = acc_sum >>> DECIM_LOG2;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pt_d       = pt_q;
        prev_pt_d  = prev_pt_q;
        pt_stb_d   = 1'b0;
        if (smp_stb) begin
            if (cnt_q == CNT_LAST) begin
                pt_d      = acc_shr[WS-1:0];
                prev_pt_d = pt_q;
                pt_stb_d  = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Decimator state registers.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            pt_q      <= '0;
            prev_pt_q <= '0;
            pt_stb_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pt_q      <= pt_d;
            prev_pt_q <= prev_pt_d;
            pt_stb_q  <= pt_stb_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM and bank control
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          trig_flag_q, trig_flag_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          valid_q, valid_d;
    logic          triggered_q, triggered_d;
    logic          frame_rdy_q, frame_rdy_d;
    logic          real_trig, swap;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    // Next-state logic: arm, capture DEPTH points, then wait for vsync to swap.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        trig_flag_d = trig_flag_q;
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        valid_d     = valid_q;
        triggered_d = triggered_q;
        frame_rdy_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr_q;
        swap        = 1'b0;
        // Free-run counts as a genuine trigger; only the timeout clears the flag.
        real_trig   = !iTRIG_EN || (prev_pt_q[WS-1] && !pt_q[WS-1]);

        case (state_q)
            ST_ARM: begin
                if (pt_stb_q) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (real_trig || (tcnt_q == TCNT_LAST)) begin
                        trig_flag_d = real_trig;
                        mem_we      = 1'b1;
                        mem_waddr   = '0;
                        wr_addr_d   = AW'(1);
                        state_d     = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (pt_stb_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr_q;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == ADDR_LAST) begin
                        state_d = ST_DONE;
                        // A vsync landing on the final write still gets this frame out.
                        swap    = vs_stb;
                    end
                end
            end
            ST_DONE: begin
                swap = vs_stb;
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase

        if (swap) begin
            rd_bank_d   = wr_bank_q;
            wr_bank_d   = ~wr_bank_q;
            triggered_d = trig_flag_q;
            valid_d     = 1'b1;
            frame_rdy_d = 1'b1;
            tcnt_d      = '0;
            state_d     = ST_ARM;
        end

        if (!iRST_N) begin
            mem_we = 1'b0;
        end
    end

    // FSM and bank-control registers.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            state_q     <= ST_ARM;
            tcnt_q      <= '0;
            trig_flag_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b1;
            rd_bank_q   <= 1'b0;
            valid_q     <= 1'b0;
            triggered_q <= 1'b0;
            frame_rdy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            trig_flag_q <= trig_flag_d;
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            valid_q     <= valid_d;
            triggered_q <= triggered_d;
            frame_rdy_q <= frame_rdy_d;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong RAM, addressed as {bank, column}
    // ------------------------------------------------------------------
    logic [WS-1:0] mem [0:(2 << AW) - 1];
    logic [WS-1:0] rd_data_q;
    logic          rd_ok;

    assign rd_ok = valid_q && ({1'b0, iRD_ADDR} < DEPTH_W);

    // Write port: capture side always writes the bank the display is not reading.
    always_ff @(posedge iCLK_50) begin
        if (mem_we) begin
            mem[{wr_bank_q, mem_waddr}] <= pt_q;
        end
    end

    // Registered read port; blank before the first frame and past the last column.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= mem[{rd_bank_q, iRD_ADDR}];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign oRD_DATA   = rd_data_q;
    assign oBANK      = rd_bank_q;
    assign oTRIGGERED = triggered_q;
    assign oFRAME_RDY = frame_rdy_q;
    assign oDBG_STATE = state_q;

endmodule
